// File: rtl/pipe_pkg.sv
// Shared types for the LEGv8 pipeline sequencing controller: shadow stage
// control record, forwarding select encoding and controller FSM states.
package pipe_pkg;
  localparam int ZERO_REG = 31;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [4:0] rn;
    logic [4:0] r2;
    logic       use_rn;
    logic       use_r2;
  } stage_ctrl_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pc_state_t;
endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one ALU operand; the EX/MEM producer beats MEM/WB
// so the youngest value of a register always wins.
module fwd_unit #(
  parameter int ZERO_REG = 31
) (
  input  logic [4:0] src,
  input  logic       use_src,
  input  logic       mem_wr,
  input  logic [4:0] mem_rd,
  input  logic       wb_wr,
  input  logic [4:0] wb_rd,
  output logic [1:0] sel
);
  import pipe_pkg::*;

  localparam logic [4:0] ZR = 5'(ZERO_REG);

  always_comb begin
    sel = FWD_RF;
    if (use_src && mem_wr && mem_rd != ZR && mem_rd == src)
      sel = FWD_MEM;
    else if (use_src && wb_wr && wb_rd != ZR && wb_rd == src)
      sel = FWD_WB;
  end
endmodule

// File: rtl/pipe_ctrl.sv
// Sequencing controller for the 5-stage LEGv8 pipeline: shadows EX/MEM/WB
// control, drives enables/flushes, hazards, forwarding and perf counters.
module pipe_ctrl #(
  parameter int CNT_W    = 16,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_r2,
  input  logic             id_use_rn,
  input  logic             id_use_r2,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_branch,
  input  logic             mem_zero,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             pc_src,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             dmem_req,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  import pipe_pkg::*;

  localparam logic [4:0] ZR = 5'(ZERO_REG);

  stage_ctrl_t ex, mem, wb, id_ctrl;
  pc_state_t   state, state_nx;
  logic        mem_pending, frozen, br_taken, load_use, stall_inc;

  assign id_ctrl = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite,
                     memread: id_memread, memwrite: id_memwrite,
                     branch: id_branch, rn: id_rn, r2: id_r2,
                     use_rn: id_use_rn, use_r2: id_use_r2};

  assign mem_pending = mem.valid & (mem.memread | mem.memwrite);
  assign dmem_req    = mem_pending;
  // Freeze starts in the same cycle the access reaches MEM, not a cycle later.
  assign frozen      = mem_pending & ~dmem_ready;
  assign br_taken    = mem.valid & mem.branch & mem_zero & ~frozen;
  assign load_use    = ex.valid & ex.memread & (ex.rd != ZR) & id_valid &
                       ((id_use_rn & (id_rn == ex.rd)) |
                        (id_use_r2 & (id_r2 == ex.rd)));
  assign stall_inc   = frozen | (~br_taken & load_use);

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:      if (frozen) state_nx = MEM_WAIT;
      MEM_WAIT: if (dmem_ready || !mem_pending) state_nx = RUN;
      default:  state_nx = RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    pc_src      = 1'b0;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    if (frozen) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (br_taken) begin
      pc_src      = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex        <= '0;
      mem       <= '0;
      wb        <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (idex_en)  ex  <= idex_bubble ? '0 : id_ctrl;
      if (exmem_en) mem <= exmem_flush ? '0 : ex;
      if (memwb_en) wb  <= mem;
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (br_taken  && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  fwd_unit #(.ZERO_REG(ZERO_REG)) u_fwd_a (
    .src(ex.rn), .use_src(ex.use_rn),
    .mem_wr(mem.valid & mem.regwrite), .mem_rd(mem.rd),
    .wb_wr(wb.valid & wb.regwrite), .wb_rd(wb.rd), .sel(fwd_a));

  fwd_unit #(.ZERO_REG(ZERO_REG)) u_fwd_b (
    .src(ex.r2), .use_src(ex.use_r2),
    .mem_wr(mem.valid & mem.regwrite), .mem_rd(mem.rd),
    .wb_wr(wb.valid & wb.regwrite), .wb_rd(wb.rd), .sel(fwd_b));

  // Shadow fields kept for completeness but not consumed by any decision.
  logic unused_bits;
  assign unused_bits = ^{ex, mem, wb};
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed cycle-by-cycle vectors for pipe_ctrl plus hand sequences for
// reset during a memory freeze and counter saturation.
module tb_pipe_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic id_valid, id_use_rn, id_use_r2, id_regwrite, id_memread, id_memwrite, id_branch;
  logic [4:0] id_rn, id_r2, id_rd;
  logic mem_zero, dmem_ready;
  logic pc_en, pc_src, ifid_en, ifid_flush, idex_en, idex_bubble;
  logic exmem_en, exmem_flush, memwb_en, dmem_req;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;
  logic s_pc_en, s_pc_src, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_bubble;
  logic s_exmem_en, s_exmem_flush, s_memwb_en, s_dmem_req;
  logic [1:0] s_fwd_a, s_fwd_b;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(16), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_r2(id_r2),
    .id_use_rn(id_use_rn), .id_use_r2(id_use_r2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_branch(id_branch), .mem_zero(mem_zero), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .pc_src(pc_src), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_bubble(idex_bubble), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_en(memwb_en), .dmem_req(dmem_req),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  // Narrow-counter instance sharing the same stimulus, for saturation.
  pipe_ctrl #(.CNT_W(4), .ZERO_REG(31)) dut4 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_r2(id_r2),
    .id_use_rn(id_use_rn), .id_use_r2(id_use_r2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_branch(id_branch), .mem_zero(mem_zero), .dmem_ready(dmem_ready),
    .pc_en(s_pc_en), .pc_src(s_pc_src), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
    .idex_en(s_idex_en), .idex_bubble(s_idex_bubble), .exmem_en(s_exmem_en),
    .exmem_flush(s_exmem_flush), .memwb_en(s_memwb_en), .dmem_req(s_dmem_req),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  typedef struct packed {
    logic valid; logic [4:0] rn, r2, rd;
    logic use_rn, use_r2, regwrite, memread, memwrite, branch;
  } ins_t;

  typedef struct packed {
    ins_t ins; logic mz, dr;
    logic [9:0] ctrl; logic [1:0] fa, fb; logic [15:0] st, fl;
  } vec_t;

  // {pc_en,pc_src,ifid_en,ifid_flush,idex_en,idex_bubble,exmem_en,exmem_flush,memwb_en,dmem_req}
  localparam logic [9:0] IDLE     = 10'b1010101010;
  localparam logic [9:0] IDLE_REQ = 10'b1010101011;
  localparam logic [9:0] STALL    = 10'b0000111010;
  localparam logic [9:0] BRANCH   = 10'b1111111110;
  localparam logic [9:0] FREEZE   = 10'b0000000001;

  function automatic ins_t nop();
    return '0;
  endfunction
  function automatic ins_t ldur(logic [4:0] rd, logic [4:0] rn);
    return '{valid:1, rn:rn, r2:0, rd:rd, use_rn:1, use_r2:0, regwrite:1, memread:1, memwrite:0, branch:0};
  endfunction
  function automatic ins_t alu(logic [4:0] rd, logic [4:0] rn, logic [4:0] rm);
    return '{valid:1, rn:rn, r2:rm, rd:rd, use_rn:1, use_r2:1, regwrite:1, memread:0, memwrite:0, branch:0};
  endfunction
  function automatic ins_t stur(logic [4:0] rt, logic [4:0] rn);
    return '{valid:1, rn:rn, r2:rt, rd:rt, use_rn:1, use_r2:1, regwrite:0, memread:0, memwrite:1, branch:0};
  endfunction
  function automatic ins_t cbz(logic [4:0] rt);
    return '{valid:1, rn:0, r2:rt, rd:0, use_rn:0, use_r2:1, regwrite:0, memread:0, memwrite:0, branch:1};
  endfunction
  function automatic vec_t mk(ins_t i, logic mz, logic dr, logic [9:0] c,
                              logic [1:0] fa, logic [1:0] fb, int st, int fl);
    return '{ins:i, mz:mz, dr:dr, ctrl:c, fa:fa, fb:fb, st:16'(st), fl:16'(fl)};
  endfunction

  task automatic drive(ins_t i, logic mz, logic dr);
    id_valid = i.valid; id_rn = i.rn; id_r2 = i.r2; id_rd = i.rd;
    id_use_rn = i.use_rn; id_use_r2 = i.use_r2; id_regwrite = i.regwrite;
    id_memread = i.memread; id_memwrite = i.memwrite; id_branch = i.branch;
    mem_zero = mz; dmem_ready = dr;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] ctrl_now();
    return {pc_en, pc_src, ifid_en, ifid_flush, idex_en, idex_bubble,
            exmem_en, exmem_flush, memwb_en, dmem_req};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    // Load-use, forwarding priority, XZR, branch over load-use, store freeze.
    tbl.push_back(mk(ldur(1,2),     0,1,IDLE,    2'b00,2'b00,0,0));
    tbl.push_back(mk(alu(2,1,3),    0,1,STALL,   2'b00,2'b00,0,0));
    tbl.push_back(mk(alu(2,1,3),    0,1,IDLE_REQ,2'b00,2'b00,1,0));
    tbl.push_back(mk(alu(4,5,6),    0,1,IDLE,    2'b01,2'b00,1,0));
    tbl.push_back(mk(alu(4,5,6),    0,1,IDLE,    2'b00,2'b00,1,0));
    tbl.push_back(mk(alu(7,4,4),    0,1,IDLE,    2'b00,2'b00,1,0));
    tbl.push_back(mk(nop(),         0,1,IDLE,    2'b10,2'b10,1,0));
    tbl.push_back(mk(ldur(31,2),    0,1,IDLE,    2'b00,2'b00,1,0));
    tbl.push_back(mk(alu(5,31,31),  0,1,IDLE,    2'b00,2'b00,1,0));
    tbl.push_back(mk(nop(),         0,1,IDLE_REQ,2'b00,2'b00,1,0));
    tbl.push_back(mk(cbz(3),        0,1,IDLE,    2'b00,2'b00,1,0));
    tbl.push_back(mk(ldur(1,2),     0,1,IDLE,    2'b00,2'b00,1,0));
    tbl.push_back(mk(alu(2,1,3),    1,1,BRANCH,  2'b00,2'b00,1,0));
    tbl.push_back(mk(cbz(3),        1,1,IDLE,    2'b00,2'b00,1,1));
    tbl.push_back(mk(nop(),         0,1,IDLE,    2'b00,2'b00,1,1));
    tbl.push_back(mk(nop(),         0,1,IDLE,    2'b00,2'b00,1,1));
    tbl.push_back(mk(stur(5,2),     0,1,IDLE,    2'b00,2'b00,1,1));
    tbl.push_back(mk(alu(9,1,1),    0,1,IDLE,    2'b00,2'b00,1,1));
    tbl.push_back(mk(alu(9,1,1),    0,0,FREEZE,  2'b00,2'b00,1,1));
    tbl.push_back(mk(alu(9,1,1),    0,0,FREEZE,  2'b00,2'b00,2,1));
    tbl.push_back(mk(alu(9,1,1),    0,0,FREEZE,  2'b00,2'b00,3,1));
    tbl.push_back(mk(alu(9,1,1),    0,1,IDLE_REQ,2'b00,2'b00,4,1));
    tbl.push_back(mk(alu(10,9,9),   0,1,IDLE,    2'b00,2'b00,4,1));
    tbl.push_back(mk(nop(),         0,1,IDLE,    2'b10,2'b10,4,1));

    drive(nop(), 0, 1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset ctrl", 32'(ctrl_now()), 32'(IDLE));
    check("reset fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    check("reset stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset flush_cnt", 32'(flush_cnt), 32'd0);
    step();

    foreach (tbl[i]) begin
      drive(tbl[i].ins, tbl[i].mz, tbl[i].dr);
      @(negedge clk);
      check($sformatf("r%0d ctrl", i), 32'(ctrl_now()), 32'(tbl[i].ctrl));
      check($sformatf("r%0d fwd_a", i), 32'(fwd_a), 32'(tbl[i].fa));
      check($sformatf("r%0d fwd_b", i), 32'(fwd_b), 32'(tbl[i].fb));
      check($sformatf("r%0d stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].st));
      check($sformatf("r%0d flush_cnt", i), 32'(flush_cnt), 32'(tbl[i].fl));
      step();
    end

    // Reset while parked in MEM_WAIT.
    drive(stur(5,2), 0, 1); step();
    drive(nop(), 0, 1);     step();
    drive(nop(), 0, 0);
    @(negedge clk);
    check("freeze first cycle", 32'(ctrl_now()), 32'(FREEZE));
    step();
    @(negedge clk);
    check("freeze mem_wait", 32'(ctrl_now()), 32'(FREEZE));
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("post-reset ctrl", 32'(ctrl_now()), 32'(IDLE));
    check("post-reset dmem_req", 32'(dmem_req), 32'd0);
    check("post-reset stall_cnt", 32'(stall_cnt), 32'd0);
    check("post-reset flush_cnt", 32'(flush_cnt), 32'd0);
    step();

    // Stream of load-use pairs, alternating the operand that hits.
    for (int p = 0; p < 20; p++) begin
      drive(ldur(1,2), 0, 1); step();
      drive((p % 2 == 0) ? alu(2,1,3) : alu(2,3,1), 0, 1);
      if (p == 1) begin
        @(negedge clk);
        check("r2 load-use stall", 32'(ctrl_now()), 32'(STALL));
      end
      step(); step();
      drive(nop(), 0, 1);
      if (p == 14 || p == 19) begin
        @(negedge clk);
        check($sformatf("sat p%0d wide", p), 32'(stall_cnt), 32'(p + 1));
        check($sformatf("sat p%0d narrow", p), 32'(s_stall_cnt), 32'd15);
      end
    end
    check("sat narrow flush", 32'(s_flush_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
